// File: rtl/ascensor_pkg.sv
// Shared definitions for the elevator cab-motion controller.
// Contents:
//   - N_PISOS_DEF: default number of floors, which is also the request vector width.
//   - PISO_W:      width of a floor index.
//   - estado_t:    encoding of the controller states.
package ascensor_pkg;

    localparam int unsigned N_PISOS_DEF = 10;
    localparam int unsigned PISO_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUBIENDO = 2'd1,
        ST_BAJANDO  = 2'd2,
        ST_PUERTA   = 2'd3
    } estado_t;

endpackage

// File: rtl/ascensor_buscador.sv
// Request locator. This is purely combinational logic. It reports where
// pending requests sit relative to a given floor.
// Ports:
//   solicitudes  in   N_PISOS  request vector; bit i set means floor i is requested.
//   piso_actual  in   PISO_W   reference floor.
//   hay_arriba   out  1        some request above the reference floor.
//   hay_abajo    out  1        some request below the reference floor.
//   hay_aqui     out  1        request pending at the reference floor itself.
module ascensor_buscador
    import ascensor_pkg::*;
#(
    parameter int unsigned N_PISOS = N_PISOS_DEF
) (
    input  logic [N_PISOS-1:0] solicitudes,
    input  logic [PISO_W-1:0]  piso_actual,
    output logic               hay_arriba,
    output logic               hay_abajo,
    output logic               hay_aqui
);

    always_comb begin
        hay_arriba = 1'b0;
        hay_abajo  = 1'b0;
        hay_aqui   = 1'b0;
        for (int i = 0; i < int'(N_PISOS); i++) begin
            if (i > int'(piso_actual)) begin
                hay_arriba = hay_arriba | solicitudes[i];
            end else if (i < int'(piso_actual)) begin
                hay_abajo = hay_abajo | solicitudes[i];
            end else begin
                hay_aqui = solicitudes[i];
            end
        end
    end

endmodule

// File: rtl/ascensor_control.sv
// Elevator cab-motion controller. It serves the registered request vector
// with a SCAN policy, drives the motor and the door, and tracks the current
// floor.
// Ports:
//   clk          in   1        clock; all state changes on the rising edge.
//   reset        in   1        synchronous, active-high reset.
//   solicitudes  in   N_PISOS  registered request vector.
//   piso_actual  out  PISO_W   current floor index.
//   motor_subir  out  1        drive the cab up.
//   motor_bajar  out  1        drive the cab down.
//   puerta_abrir out  1        door open.
//   direccion    out  1        last travel direction; 1 = up, 0 = down.
//   limpiar      out  N_PISOS  one-hot clear mask for the floor being served.
//                              The request register uses it as
//                              D = (Q | new) & ~limpiar.
module ascensor_control
    import ascensor_pkg::*;
#(
    parameter int unsigned N_PISOS  = N_PISOS_DEF,
    parameter int unsigned T_PISO   = 8,
    parameter int unsigned T_PUERTA = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PISOS-1:0] solicitudes,
    output logic [PISO_W-1:0]  piso_actual,
    output logic               motor_subir,
    output logic               motor_bajar,
    output logic               puerta_abrir,
    output logic               direccion,
    output logic [N_PISOS-1:0] limpiar
);

    localparam int unsigned T_MAX = (T_PISO > T_PUERTA) ? T_PISO : T_PUERTA;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] RECARGA_PISO   = TW'(T_PISO - 1);
    localparam logic [TW-1:0] RECARGA_PUERTA = TW'(T_PUERTA - 1);

    estado_t           estado_q, estado_d;
    logic [PISO_W-1:0] piso_q, piso_d;
    logic              dir_q, dir_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              arriba, abajo, aqui;
    logic [PISO_W-1:0] piso_vecino;
    logic              v_arriba, v_abajo, v_aqui;
    logic              ir_subir, ir_bajar;

    // Requests relative to the floor the cab currently occupies.
    ascensor_buscador #(
        .N_PISOS (N_PISOS)
    ) u_buscador_actual (
        .solicitudes (solicitudes),
        .piso_actual (piso_q),
        .hay_arriba  (arriba),
        .hay_abajo   (abajo),
        .hay_aqui    (aqui)
    );

    // Requests relative to the floor the cab is arriving at. The arrival
    // decision is taken against the new floor on the same edge that the cab
    // reaches it.
    ascensor_buscador #(
        .N_PISOS (N_PISOS)
    ) u_buscador_vecino (
        .solicitudes (solicitudes),
        .piso_actual (piso_vecino),
        .hay_arriba  (v_arriba),
        .hay_abajo   (v_abajo),
        .hay_aqui    (v_aqui)
    );

    always_comb begin
        piso_vecino = piso_q;
        if (estado_q == ST_SUBIENDO) begin
            piso_vecino = piso_q + PISO_W'(1);
        end else if (estado_q == ST_BAJANDO) begin
            piso_vecino = piso_q - PISO_W'(1);
        end
    end

    // The cab keeps its current direction while work remains that way.
    // Otherwise it reverses.
    assign ir_subir = arriba && (dir_q || !abajo);
    assign ir_bajar = abajo && (!dir_q || !arriba);

    always_comb begin
        estado_d = estado_q;
        piso_d   = piso_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        case (estado_q)
            ST_IDLE: begin
                if (aqui) begin
                    estado_d = ST_PUERTA;
                    timer_d  = RECARGA_PUERTA;
                end else if (ir_subir) begin
                    estado_d = ST_SUBIENDO;
                    dir_d    = 1'b1;
                    timer_d  = RECARGA_PISO;
                end else if (ir_bajar) begin
                    estado_d = ST_BAJANDO;
                    dir_d    = 1'b0;
                    timer_d  = RECARGA_PISO;
                end
            end
            ST_SUBIENDO, ST_BAJANDO: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    piso_d = piso_vecino;
                    if (v_aqui) begin
                        estado_d = ST_PUERTA;
                        timer_d  = RECARGA_PUERTA;
                    end else if ((estado_q == ST_SUBIENDO) ? v_arriba : v_abajo) begin
                        timer_d = RECARGA_PISO;
                    end else begin
                        estado_d = ST_IDLE;
                    end
                end
            end
            ST_PUERTA: begin
                // The request at this floor is ignored here. The door closes
                // on its own timer, so a re-press cannot extend the stop.
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    estado_d = ST_IDLE;
                end
            end
            default: begin
                estado_d = ST_IDLE;
                timer_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= ST_IDLE;
            piso_q   <= '0;
            dir_q    <= 1'b1;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            piso_q   <= piso_d;
            dir_q    <= dir_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        motor_subir  = (estado_q == ST_SUBIENDO);
        motor_bajar  = (estado_q == ST_BAJANDO);
        puerta_abrir = (estado_q == ST_PUERTA);
        for (int i = 0; i < int'(N_PISOS); i++) begin
            limpiar[i] = puerta_abrir && (int'(piso_q) == i);
        end
    end

    assign piso_actual = piso_q;
    assign direccion   = dir_q;

endmodule

// File: tb/tb_ascensor_control.sv
// Self-checking bench for ascensor_control. The bench models the upstream
// request register. Each scenario pushes its expected cycle-by-cycle outputs
// into a queue. The queue is then drained and compared against the DUT on
// falling edges.
module tb_ascensor_control;

    localparam int NP = 10;
    localparam int TP = 8;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] press;
    logic [NP-1:0] req_q;
    logic [3:0]    piso_actual;
    logic          motor_subir, motor_bajar, puerta_abrir, direccion;
    logic [NP-1:0] limpiar;

    typedef struct packed {
        logic [3:0]    piso;
        logic          sub;
        logic          baj;
        logic          pue;
        logic          dir;
        logic [NP-1:0] lim;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Upstream request register, with the served floor retired through limpiar.
    always_ff @(posedge clk) begin
        if (reset) req_q <= '0;
        else       req_q <= (req_q | press) & ~limpiar;
    end

    ascensor_control #(
        .N_PISOS  (NP),
        .T_PISO   (TP),
        .T_PUERTA (TD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .solicitudes  (req_q),
        .piso_actual  (piso_actual),
        .motor_subir  (motor_subir),
        .motor_bajar  (motor_bajar),
        .puerta_abrir (puerta_abrir),
        .direccion    (direccion),
        .limpiar      (limpiar)
    );

    function automatic exp_t observed();
        return {piso_actual, motor_subir, motor_bajar, puerta_abrir, direccion, limpiar};
    endfunction

    function automatic void push_n(input int piso, input bit sub, input bit baj, input bit pue,
                                   input bit dir, input int n);
        exp_t e;
        e.piso = 4'(piso);
        e.sub  = sub;
        e.baj  = baj;
        e.pue  = pue;
        e.dir  = dir;
        e.lim  = pue ? (NP'(1) << piso) : '0;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endfunction

    function automatic void push_sub(input int from, input int to);
        for (int p = from; p < to; p++) push_n(p, 1, 0, 0, 1, TP);
    endfunction

    function automatic void push_baj(input int from, input int to);
        for (int p = from; p > to; p--) push_n(p, 0, 1, 0, 0, TP);
    endfunction

    task automatic test_reset();
        exp_t e, o;
        int   c;
        reset = 1'b1;
        press = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_n(0, 0, 0, 0, 1, 50);
        c = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = observed();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_idle c=%0d: got %h required %h", c, o, e);
            end
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_floor3();
        exp_t e, o;
        int   c;
        push_n(0, 0, 0, 0, 1, 1);
        push_sub(0, 3);
        push_n(3, 0, 0, 1, 1, TD);
        push_n(3, 0, 0, 0, 1, 2);
        press = NP'(1) << 3;
        @(negedge clk);
        press = '0;
        c = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = observed();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL floor3 c=%0d: got %h required %h", c, o, e);
            end
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_scan();
        exp_t e, o;
        int   c, k;
        // First bring the cab from 3 up to 5. Then request floors 2 and 8 together.
        push_n(3, 0, 0, 0, 1, 1);
        push_sub(3, 5);
        push_n(5, 0, 0, 1, 1, TD);
        push_n(5, 0, 0, 0, 1, 2);
        k = exp_q.size() - 1;
        push_n(5, 0, 0, 0, 1, 1);
        push_sub(5, 8);
        push_n(8, 0, 0, 1, 1, TD);
        push_n(8, 0, 0, 0, 1, 1);
        push_baj(8, 2);
        push_n(2, 0, 0, 1, 0, TD);
        push_n(2, 0, 0, 0, 0, 2);
        press = NP'(1) << 5;
        @(negedge clk);
        press = '0;
        c = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = observed();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL scan c=%0d: got %h required %h", c, o, e);
            end
            press = (c == k) ? ((NP'(1) << 2) | (NP'(1) << 8)) : '0;
            @(negedge clk);
            c++;
        end
        press = '0;
    endtask

    task automatic test_reset_mid_travel();
        exp_t e, o;
        int   c;
        push_n(2, 0, 0, 0, 0, 1);
        push_sub(2, 6);
        push_n(6, 1, 0, 0, 1, 3);
        press = NP'(1) << 8;
        @(negedge clk);
        press = '0;
        c = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = observed();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pre_reset c=%0d: got %h required %h", c, o, e);
            end
            @(negedge clk);
            c++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        push_n(0, 0, 0, 0, 1, 3);
        c = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = observed();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_mid c=%0d: got %h required %h", c, o, e);
            end
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_stop_midway();
        exp_t e, o;
        int   c;
        push_n(0, 0, 0, 0, 1, 1);
        push_sub(0, 2);
        push_n(2, 0, 0, 1, 1, TD);
        push_n(2, 0, 0, 0, 1, 1);
        push_sub(2, 4);
        push_n(4, 0, 0, 1, 1, TD);
        push_n(4, 0, 0, 0, 1, 2);
        press = NP'(1) << 4;
        @(negedge clk);
        press = '0;
        c = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = observed();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL stop_midway c=%0d: got %h required %h", c, o, e);
            end
            // Floor 2 is pressed while the cab is still moving away from floor 0.
            press = (c == 5) ? (NP'(1) << 2) : '0;
            @(negedge clk);
            c++;
        end
        press = '0;
    endtask

    task automatic test_door_repress();
        exp_t e, o;
        int   c;
        push_n(4, 0, 0, 0, 1, 1);
        push_baj(4, 3);
        push_n(3, 0, 0, 1, 0, TD);
        push_n(3, 0, 0, 0, 0, 3);
        press = NP'(1) << 3;
        @(negedge clk);
        press = '0;
        c = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = observed();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL door_repress c=%0d: got %h required %h", c, o, e);
            end
            // Re-press floor 3 on the 2nd and on the last door cycle.
            press = (c == 10 || c == 12) ? (NP'(1) << 3) : '0;
            @(negedge clk);
            c++;
        end
        press = '0;
    endtask

    task automatic test_top_floor();
        exp_t e, o;
        int   c, k;
        push_n(3, 0, 0, 0, 0, 1);
        push_sub(3, 9);
        push_n(9, 0, 0, 1, 1, TD);
        push_n(9, 0, 0, 0, 1, 2);
        k = exp_q.size() - 1;
        push_n(9, 0, 0, 0, 1, 1);
        push_n(9, 0, 0, 1, 1, TD);
        push_n(9, 0, 0, 0, 1, 3);
        press = NP'(1) << 9;
        @(negedge clk);
        press = '0;
        c = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = observed();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL top_floor c=%0d: got %h required %h", c, o, e);
            end
            press = (c == k) ? (NP'(1) << 9) : '0;
            @(negedge clk);
            c++;
        end
        press = '0;
    endtask

    initial begin
        reset = 1'b1;
        press = '0;
        test_reset();
        test_floor3();
        test_scan();
        test_reset_mid_travel();
        test_stop_midway();
        test_door_repress();
        test_top_floor();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
